// File: rtl/miner_mc_csr.sv
// Avalon-MM control/status block for a bank of mining cores.
// Holds header/difficulty/start/stride, fans start nonces out to the cores,
// collects found solutions through per-core pending flags into a small FIFO.
module miner_mc_csr #(
   parameter int CORES      = 4,
   parameter int NONCE_W    = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [4:0]                 address,
   input  logic                       read,
   input  logic                       write,
   input  logic [31:0]                writedata,
   output logic [31:0]                readdata,
   output logic                       irq,
   output logic [255:0]               core_header,
   output logic [255:0]               core_difficulty,
   output logic [CORES*NONCE_W-1:0]   core_start_nonce,
   output logic [CORES-1:0]           core_run,
   output logic [CORES-1:0]           core_load,
   input  logic [CORES-1:0]           core_found,
   input  logic [CORES*NONCE_W-1:0]   core_solution
);

   localparam int NW = NONCE_W / 32;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int EW = 8 + NONCE_W;
   localparam logic [4:0]  SOLN_TOP = 5'(4 + NW - 1);
   localparam logic [31:0] ID_WORD  = 32'h5348_4133;

   logic              run_q, run_d, halt_q, halt_d, irq_en_q, irq_en_d;
   logic              run_dly_q, run_dly_d, load_q, load_d;
   logic              ovf_q, ovf_d, irq_q, irq_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       hdr_q [8], hdr_d [8];
   logic [31:0]       diff_q [8], diff_d [8];
   logic [31:0]       start_q [4], start_d [4];
   logic [31:0]       stride_q [4], stride_d [4];
   logic [CORES-1:0]  pend_q, pend_d;
   logic [NONCE_W-1:0] pnonce_q [CORES], pnonce_d [CORES];
   logic [EW-1:0]     mem_q [FIFO_DEPTH], mem_d [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic              flush, clr_ovf, sel_valid, do_push, do_pop, full, nonempty, running;
   logic [7:0]        sel_idx;
   logic [NONCE_W-1:0] sel_nonce, start_v, stride_v;
   logic [EW-1:0]     head;

   assign nonempty = (cnt_q != '0);
   assign full     = (cnt_q == CW'(FIFO_DEPTH));
   assign head     = mem_q[rd_ptr_q];
   assign core_run = {CORES{run_q & ~halt_q}};
   assign running  = |core_run;
   assign core_load = {CORES{load_q}};
   assign readdata = rdata_q;
   assign irq      = irq_q;

   // Register-file write decode; CTL bits 8/9 are one-shot actions.
   always_comb begin
      run_d    = run_q;
      halt_d   = halt_q;
      irq_en_d = irq_en_q;
      hdr_d    = hdr_q;
      diff_d   = diff_q;
      start_d  = start_q;
      stride_d = stride_q;
      clr_ovf  = 1'b0;
      flush    = 1'b0;
      if (write) begin
         if (address == 5'd2) begin
            run_d    = writedata[0];
            halt_d   = writedata[1];
            irq_en_d = writedata[2];
            clr_ovf  = writedata[8];
            flush    = writedata[9];
         end else if (address[4:3] == 2'b01) begin
            hdr_d[address[2:0]] = writedata;
         end else if (address[4:3] == 2'b11) begin
            diff_d[address[2:0]] = writedata;
         end else if (address[4:2] == 3'b100) begin
            if (int'(address[1:0]) < NW) start_d[address[1:0]] = writedata;
         end else if (address[4:2] == 3'b101) begin
            if (int'(address[1:0]) < NW) stride_d[address[1:0]] = writedata;
         end
      end
   end

   // Header/difficulty fan-out (word 0 on the top bits) and per-core start nonces.
   always_comb begin
      start_v  = '0;
      stride_v = '0;
      for (int k = 0; k < NW; k++) begin
         start_v[32*k +: 32]  = start_q[k];
         stride_v[32*k +: 32] = stride_q[k];
      end
      for (int k = 0; k < 8; k++) begin
         core_header[255-32*k -: 32]     = hdr_q[k];
         core_difficulty[255-32*k -: 32] = diff_q[k];
      end
      for (int i = 0; i < CORES; i++)
         core_start_nonce[i*NONCE_W +: NONCE_W] = start_v + stride_v * NONCE_W'(i);
   end

   // Pending capture, lowest-index drain into the FIFO, pop on top SOLN word read.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      sel_nonce = '0;
      for (int i = CORES - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            sel_valid = 1'b1;
            sel_idx   = 8'(i);
            sel_nonce = pnonce_q[i];
         end
      end
      pend_d   = pend_q;
      pnonce_d = pnonce_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      do_pop   = read && (address == SOLN_TOP) && nonempty;
      do_push  = sel_valid && !full && !flush;
      if (sel_valid) pend_d[sel_idx[$clog2(CORES+1)-1:0]] = 1'b0;
      for (int i = 0; i < CORES; i++) begin
         if (core_found[i]) begin
            pend_d[i]   = 1'b1;
            pnonce_d[i] = core_solution[i*NONCE_W +: NONCE_W];
         end
      end
      if (clr_ovf) ovf_d = 1'b0;
      if (flush) begin
         pend_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (sel_valid && full) ovf_d = 1'b1;
         if (do_push) begin
            mem_d[wr_ptr_q] = {sel_idx, sel_nonce};
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Read mux, load-pulse edge detect and registered interrupt.
   always_comb begin
      run_dly_d = run_q;
      load_d    = run_q & ~run_dly_q;
      irq_d     = irq_en_q & (nonempty | ovf_q);
      rdata_d   = '0;
      if (read) begin
         if (address == 5'd0) rdata_d = ID_WORD;
         else if (address == 5'd1)
            rdata_d = {8'd0, 8'(NW), 3'd0, 5'(cnt_q), 4'(CORES), 1'b0, running, ovf_q, nonempty};
         else if (address == 5'd2) rdata_d = {29'd0, irq_en_q, halt_q, run_q};
         else if (address == 5'd3) rdata_d = nonempty ? {1'b1, 23'd0, head[EW-1 -: 8]} : 32'd0;
         else if (address[4:3] == 2'b01) rdata_d = hdr_q[address[2:0]];
         else if (address[4:3] == 2'b11) rdata_d = diff_q[address[2:0]];
         else if (address[4:2] == 3'b100) begin
            if (int'(address[1:0]) < NW) rdata_d = start_q[address[1:0]];
         end else if (address[4:2] == 3'b101) begin
            if (int'(address[1:0]) < NW) rdata_d = stride_q[address[1:0]];
         end else begin
            for (int k = 0; k < NW; k++)
               if (address == 5'(4 + k) && nonempty) rdata_d = head[32*k +: 32];
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_q     <= 1'b0;
         halt_q    <= 1'b0;
         irq_en_q  <= 1'b0;
         run_dly_q <= 1'b0;
         load_q    <= 1'b0;
         ovf_q     <= 1'b0;
         irq_q     <= 1'b0;
         rdata_q   <= '0;
         pend_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         for (int k = 0; k < 8; k++) begin
            hdr_q[k]  <= '0;
            diff_q[k] <= '0;
         end
         for (int k = 0; k < 4; k++) begin
            start_q[k]  <= '0;
            stride_q[k] <= '0;
         end
         for (int i = 0; i < CORES; i++) pnonce_q[i] <= '0;
         for (int e = 0; e < FIFO_DEPTH; e++) mem_q[e] <= '0;
      end else begin
         run_q     <= run_d;
         halt_q    <= halt_d;
         irq_en_q  <= irq_en_d;
         run_dly_q <= run_dly_d;
         load_q    <= load_d;
         ovf_q     <= ovf_d;
         irq_q     <= irq_d;
         rdata_q   <= rdata_d;
         pend_q    <= pend_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         hdr_q     <= hdr_d;
         diff_q    <= diff_d;
         start_q   <= start_d;
         stride_q  <= stride_d;
         pnonce_q  <= pnonce_d;
         mem_q     <= mem_d;
      end
   end

endmodule

// File: doc/miner_mc_csr.md
MINER_MC_CSR -- requirements
Module: miner_mc_csr

Interface
REQ-001 SHALL have parameter CORES, default 4, meaning number of mining cores served (1..8).
REQ-002 SHALL have parameter NONCE_W, default 64, meaning nonce width in bits (64 or 128), NW = NONCE_W/32.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning solution FIFO entries (power of 2, 2..16).
REQ-004 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port address, input, 5, meaning Avalon-MM word address.
REQ-007 SHALL have ports read and write, input, 1 each, meaning Avalon-MM strobes.
REQ-008 SHALL have ports writedata (input) and readdata (output reg), 32 each, meaning Avalon-MM data.
REQ-009 SHALL have port irq, output, 1, meaning active-high level interrupt.
REQ-010 SHALL have ports core_header and core_difficulty, output, 256 each, meaning word 0 of the block in bits 255:224.
REQ-011 SHALL have port core_start_nonce, output, CORES*NONCE_W, meaning per-core start nonce, core i in slice i.
REQ-012 SHALL have ports core_run (output), core_load (output) and core_found (input), CORES each, meaning run enable, one-cycle load pulse and one-cycle found pulse.
REQ-013 SHALL have port core_solution, input, CORES*NONCE_W, meaning per-core solution nonce, valid with core_found.

Function
REQ-014 SHALL decode word map: 0 ID RO "SHA3"; 1 STATUS RO; 2 CTL RW; 3 SOLN_ID RO; 4..4+NW-1 SOLN RO (LS word first); 8..15 HDR RW; 16..19 START RW; 20..23 STRIDE RW (LS first); NONCE_W=64 uses only the first 2 words of SOLN/START/STRIDE.
REQ-015 SHALL return readdata one cycle after read; unmapped addresses and unused words read 0.
REQ-016 SHALL map DIFF to words 24..31, RW.
REQ-017 SHALL define CTL bits: [0] run, [1] halt, [2] irq_en; [8] clear overflow and [9] flush FIFO are write-1 self-clearing actions, always read 0.
REQ-018 SHALL define STATUS bits: [0] FIFO non-empty, [1] overflow sticky, [2] running, [7:4] CORES, [12:8] FIFO count, [23:16] NW.
REQ-019 SHALL drive core_start_nonce slice i = START + i*STRIDE, modulo 2^NONCE_W, with the multiply being combinational or registered before core_load.
REQ-020 SHALL drive core_run[i] = run & ~halt for all i; running = |core_run.
REQ-021 SHALL pulse core_load on all cores for exactly one cycle, the cycle after CTL.run transitions 0->1.
REQ-022 SHALL capture each core_found pulse into a per-core pending flag plus nonce register; a new pulse on a pending core overwrites the nonce.
REQ-023 SHALL push at most one pending entry per cycle into the FIFO, lowest core index first, storing {core index, nonce}, and clear that core's flag.
REQ-024 SHALL discard the selected entry when the FIFO is full, clear its flag, and set overflow.
REQ-025 SHALL return the head entry at SOLN_ID: [7:0] core index, [31] valid.
REQ-026 SHALL pop the FIFO on a read of the top SOLN word (address 4+NW-1) when non-empty; reading an empty FIFO returns 0 with no pop.
REQ-027 SHALL count correctly on a simultaneous push and pop in one cycle.
REQ-028 SHALL empty the FIFO and clear all pending flags on flush, giving flush priority over a push in the same cycle.
REQ-029 SHALL drive irq = irq_en & (non-empty | overflow), registered, one cycle latency.

Reset
REQ-030 SHALL clear, on rst, readdata, irq, core_run, core_load, all RW registers, pending flags, FIFO pointers/count and overflow.
REQ-031 SHALL immediately abort a run in progress on rst and hold core_load low in the cycle after reset releases.

Verification
REQ-032 SHALL cover: CORES=4, START=0x100, STRIDE=0x1000, run=1 -> core_load pulse 1 cycle, slices 0x100/0x1100/0x2100/0x3100.
REQ-033 SHALL cover: core_found=4'b1010 same cycle -> FIFO gets core 1 then core 3; SOLN_ID reads 0x80000001 then 0x80000003.
REQ-034 SHALL cover: 5 founds with FIFO_DEPTH=4 and no reads -> count 4, STATUS[1]=1, irq=1 with irq_en; CTL write 0x100 clears overflow.
REQ-035 SHALL cover: read SOLN word 1 (NW=2) on non-empty FIFO -> count decrements; read on empty -> 0, count 0.
REQ-036 SHALL cover: push and pop same cycle at count 2 -> count stays 2; flush with concurrent found -> count 0.
REQ-037 SHALL cover: rst asserted mid-run with pending entries -> next cycle core_run=0, irq=0, STATUS=0x00020040.
